regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two writeback sources: the ALU result path and the load-return path.
- Buffers ALU results in a 2-entry FIFO.
- Keeps a pending-load scoreboard so the issue stage can stall on RAW/WAW hazards.
- Sits between execute/memory stages and register_file; drives its write, inAddress and in inputs.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- ALU_DEPTH, 2, ALU result FIFO entries (power of two, >=2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU FIFO can accept (not full)
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- load_valid  input  1  load data returned
- load_ready  output  1  load path accepted this cycle
- load_rd  input  ADDR_W  load destination register
- load_data  input  DATA_W  load data
- issue_load  input  1  issue stage dispatching a load this cycle
- issue_rd  input  ADDR_W  destination of issued load
- rs1  input  ADDR_W  issue-stage source 1
- rs2  input  ADDR_W  issue-stage source 2
- rd_chk  input  ADDR_W  issue-stage destination, for WAW check
- hazard  output  1  combinational: issue must stall
- rf_write  output  1  register file write enable (registered)
- rf_waddr  output  ADDR_W  register file write address (registered)
- rf_wdata  output  DATA_W  register file write data (registered)

Behaviour:
- Reset (rst low, async): FIFO empty; scoreboard all zero; rf_write=0, rf_waddr=0, rf_wdata=0; alu_ready=1; load_ready=0 (combinational, valid low).
- ALU FIFO:
  - push on alu_valid & alu_ready; alu_ready = !full.
  - push when full is impossible by handshake.
  - push and pop in the same cycle is allowed, including when full; count stays unchanged.
  - pointers wrap modulo ALU_DEPTH.
- Arbitration each cycle, FIFO head only, no bypass:
  - load_valid & !fifo_full -> load wins; load_ready=1.
  - load_valid & fifo_full -> FIFO head wins; load_ready=0 (load source holds its values).
  - !load_valid & !fifo_empty -> FIFO head wins.
  - nothing pending -> no write.
- Writeback register: winner's rd/data are loaded into rf_waddr/rf_wdata, and rf_write=1 on the next edge.
  - Winner with rd==0: consumed (popped/accepted) but rf_write=0.
  - Internal flag wb_is_load records that the write came from the load path.
- Latency:
  - load accepted in cycle N -> rf_write high in cycle N+1.
  - ALU pushed in cycle N -> earliest rf_write in cycle N+2.
- Scoreboard (32-bit pending mask, bit 0 hard-wired 0):
  - set bit issue_rd on issue_load.
  - clear bit rf_waddr at the edge ending a cycle where rf_write & wb_is_load.
  - set and clear of the same register in one cycle -> set wins.
- Hazard (combinational): asserted when any of:
  - pending[rs1], pending[rs2], or pending[rd_chk];
  - rd_chk!=0 and it matches the rd of any valid FIFO entry while issue_load is high, so a load cannot overtake a buffered ALU write;
  - rs1 or rs2 (nonzero) matches rd of a valid FIFO entry or the registered rf_waddr while rf_write.
- Ordering: ALU results retire in FIFO order; loads retire in acceptance order.
- Reset mid-operation: FIFO contents, scoreboard and in-flight write are discarded immediately; no write occurs after rst falls.

Decomposition:
- Shared package: DATA_W/ADDR_W constants; a wb_entry_t struct {rd, data}; the REG_ZERO constant.
- One sub-module, wb_fifo: parameterised synchronous FIFO with full/empty/count and head peek of all entries for hazard compare.
- Arbitration, writeback register and scoreboard live in the top module.

Test Plan:
- Reset then idle: rst low mid-cycle -> rf_write=0, rf_waddr=0, hazard=0, alu_ready=1 asynchronously; stays idle with no valids.
- ALU only: push (rd=5, 0xDEADBEEF) at cycle 1 -> rf_write=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 3, single cycle.
- Conflict:
  - Stimulus: FIFO holds (rd=3, 0x11), load_valid (rd=7, 0x22) same cycle.
  - Response: load writes first, next cycle rd=3.
  - Fill FIFO to 2 with load_valid held -> load_ready=0 and FIFO head drains before load.
- Scoreboard:
  - Stimulus: issue_load rd=9; then rs1=9.
  - Response: hazard=1 until the cycle after the load writeback of rd=9, then 0.
  - issue_load rd=9 in the same cycle as the rd=9 load write -> bit stays set.
- x0 handling: ALU rd=0 and load rd=0 are consumed with rf_write=0; issue_load rd=0 never raises hazard.
- Overflow/wrap: 10 back-to-back ALU pushes with load_valid idle -> all 10 written in order, alu_ready never drops, and pointers wrap cleanly.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback sources, issue-stage hazard query and register-file write port.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_rd;
  logic [DATA_W-1:0] load_data;
  logic              issue_load;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd_chk;
  logic              hazard;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
           issue_load, issue_rd, rs1, rs2, rd_chk,
    input  alu_ready, load_ready, hazard, rf_write, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
           issue_load, issue_rd, rs1, rs2, rd_chk,
    output alu_ready, load_ready, hazard, rf_write, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small synchronous FIFO exposing every slot and its occupancy for hazard compares.
module wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  output entry_t                  head,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        count,
  output entry_t [DEPTH-1:0]      slots,
  output logic [DEPTH-1:0]        slot_valid
);

  entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign slots   = mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    logic [PTR_W-1:0] offset;
    slot_valid = '0;
    offset     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rd_ptr;
      slot_valid[i] = (CNT_W'(offset) < count);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: arbitrates ALU FIFO vs load return,
// registers the write, and tracks pending loads for issue-stage stalls.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W,
  parameter int unsigned ADDR_W    = RF_ADDR_W,
  parameter int unsigned ALU_DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(ALU_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  entry_t                 fifo_head;
  entry_t                 push_entry;
  entry_t [ALU_DEPTH-1:0] fifo_slots;
  logic [ALU_DEPTH-1:0]   fifo_slot_valid;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   alu_push;
  logic                   load_win;
  entry_t                 win;
  logic                   win_valid;

  logic                   rf_write;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic                   wb_is_load;
  logic [NREGS-1:0]       pending;
  logic [NREGS-1:0]       pending_next;
  logic                   hazard;

  assign push_entry = '{rd: bus.alu_rd, data: bus.alu_data};
  assign alu_push   = bus.alu_valid & bus.alu_ready;

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (ALU_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (alu_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .slots      (fifo_slots),
    .slot_valid (fifo_slot_valid)
  );

  // Loads win unless the FIFO is full, which would otherwise starve ALU pushes.
  assign load_win  = bus.load_valid & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & ~load_win;
  assign win_valid = load_win | fifo_pop;
  assign win       = load_win ? entry_t'{rd: bus.load_rd, data: bus.load_data} : fifo_head;

  assign bus.alu_ready  = (fifo_count < CNT_W'(ALU_DEPTH));
  assign bus.load_ready = load_win;
  assign bus.rf_write   = rf_write;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.hazard     = hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write   <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      wb_is_load <= 1'b0;
      pending    <= '0;
    end else begin
      rf_write   <= win_valid & (win.rd != RZ);
      wb_is_load <= load_win;
      if (win_valid) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
      pending <= pending_next;
    end
  end

  // Set is applied after clear so a re-issued load to the same register stays pending.
  always_comb begin
    pending_next = pending;
    if (rf_write & wb_is_load) pending_next[rf_waddr] = 1'b0;
    if (bus.issue_load)        pending_next[bus.issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    hazard = pending[bus.rs1] | pending[bus.rs2] | pending[bus.rd_chk];
    for (int unsigned i = 0; i < ALU_DEPTH; i++) begin
      if (fifo_slot_valid[i]) begin
        if (bus.issue_load && bus.rd_chk != RZ && fifo_slots[i].rd == bus.rd_chk) hazard = 1'b1;
        if (bus.rs1 != RZ && fifo_slots[i].rd == bus.rs1) hazard = 1'b1;
        if (bus.rs2 != RZ && fifo_slots[i].rd == bus.rs2) hazard = 1'b1;
      end
    end
    if (rf_write) begin
      if (bus.rs1 != RZ && rf_waddr == bus.rs1) hazard = 1'b1;
      if (bus.rs2 != RZ && rf_waddr == bus.rs2) hazard = 1'b1;
    end
  end

endmodule
